// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Holds the access-size and FSM-state encodings plus the alignment rule.
package lsu_pkg;

    localparam int LSU_DM_AW = 10;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        INV  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } lsu_state_t;

    function automatic logic misaligned(input size_t size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            BYTE:    bad = 1'b0;
            HALF:    bad = addr_lo[0];
            WORD:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Pipeline-side request/response handshake of the load/store unit.
// The pipeline is the master; the LSU is the slave.
interface dm_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
// Purely combinational; callers guarantee the access is aligned.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] dm_out,
    input  logic [1:0]  addr_lo,
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0]  sh_s;
    logic [31:0] lane_s;

    assign sh_s   = {addr_lo, 3'b000};
    assign lane_s = dm_out >> sh_s;

    // Aligned halves have addr_lo[0]=0, so one byte-granular shift serves both sizes.
    always_comb begin
        load_data  = 32'd0;
        store_data = old_word;
        case (size)
            BYTE: begin
                load_data  = {{24{sign_ext & lane_s[7]}}, lane_s[7:0]};
                store_data = (old_word & ~(32'h0000_00FF << sh_s)) | ({24'd0, wdata[7:0]} << sh_s);
            end
            HALF: begin
                load_data  = {{16{sign_ext & lane_s[15]}}, lane_s[15:0]};
                store_data = (old_word & ~(32'h0000_FFFF << sh_s)) | ({16'd0, wdata[15:0]} << sh_s);
            end
            WORD: begin
                load_data  = dm_out;
                store_data = wdata;
            end
            default: begin
                load_data  = 32'd0;
                store_data = old_word;
            end
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Memory-stage load/store unit driving a word-organised data memory.
// Every output register is loaded from the state held during the previous cycle.
module dm_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DM_AW  = LSU_DM_AW
) (
    input  logic              clk,
    input  logic              rst,
    dm_lsu_if.slave           bus,
    output logic              DM_read,
    output logic              DM_write,
    output logic [DM_AW-1:0]  DM_addr,
    output logic [DATA_W-1:0] DM_in,
    input  logic [DATA_W-1:0] DM_out
);

    lsu_state_t        state_r;
    logic              we_r;
    size_t             size_r;
    logic              signed_r;
    logic              err_r;
    logic [DM_AW+1:0]  addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic              dm_read_r;
    logic              dm_write_r;
    logic [DM_AW-1:0]  dm_addr_r;
    logic [DATA_W-1:0] dm_in_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    logic [DATA_W-1:0] load_data_s;
    logic [DATA_W-1:0] store_data_s;
    logic              req_err_s;

    assign req_err_s = misaligned(size_t'(bus.req_size), bus.req_addr[1:0]);

    // Old word comes straight from DM_out: the read enable is still high in RMW_WR.
    lsu_align u_align (
        .dm_out     (DM_out),
        .addr_lo    (addr_r[1:0]),
        .size       (size_r),
        .sign_ext   (signed_r),
        .old_word   (DM_out),
        .wdata      (wdata_r),
        .load_data  (load_data_s),
        .store_data (store_data_s)
    );

    // FSM, captured request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            size_r      <= BYTE;
            signed_r    <= 1'b0;
            err_r       <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            dm_read_r   <= 1'b0;
            dm_write_r  <= 1'b0;
            dm_addr_r   <= '0;
            dm_in_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            dm_read_r   <= 1'b0;
            dm_write_r  <= 1'b0;
            dm_addr_r   <= '0;
            dm_in_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
            case (state_r)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        we_r     <= bus.req_we;
                        size_r   <= size_t'(bus.req_size);
                        signed_r <= bus.req_signed;
                        err_r    <= req_err_s;
                        addr_r   <= bus.req_addr[DM_AW+1:0];
                        wdata_r  <= bus.req_wdata;
                        if (req_err_s) begin
                            state_r <= RESP;
                        end else if (!bus.req_we) begin
                            state_r <= LOAD;
                        end else if (size_t'(bus.req_size) == WORD) begin
                            state_r <= STORE;
                        end else begin
                            state_r <= RMW_RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    dm_read_r <= 1'b1;
                    dm_addr_r <= addr_r[DM_AW+1:2];
                    state_r   <= RESP;
                end
                STORE: begin
                    dm_write_r <= 1'b1;
                    dm_addr_r  <= addr_r[DM_AW+1:2];
                    dm_in_r    <= wdata_r;
                    state_r    <= RESP;
                end
                RMW_RD: begin
                    dm_read_r <= 1'b1;
                    dm_addr_r <= addr_r[DM_AW+1:2];
                    state_r   <= RMW_WR;
                end
                RMW_WR: begin
                    dm_write_r <= 1'b1;
                    dm_addr_r  <= addr_r[DM_AW+1:2];
                    dm_in_r    <= store_data_s;
                    state_r    <= RESP;
                end
                RESP: begin
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= err_r;
                    rsp_rdata_r <= (err_r || we_r) ? '0 : load_data_s;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Strobes are masked by rst so an abort also kills a pulse already on the wire.
    assign DM_read       = dm_read_r & ~rst;
    assign DM_write      = dm_write_r & ~rst;
    assign DM_addr       = dm_addr_r;
    assign DM_in         = dm_in_r;
    assign bus.req_ready = (state_r == IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_r & ~rst;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu: a byte-array reference model predicts each response,
// and a negedge monitor compares data, error flag, latency and memory-port activity.
module tb_dm_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        DM_read, DM_write;
    logic [9:0]  DM_addr;
    logic [31:0] DM_in, DM_out;

    always #5 clk = ~clk;

    dm_lsu_if bus();

    dm_lsu #(.DATA_W(32), .DM_AW(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .DM_read  (DM_read),
        .DM_write (DM_write),
        .DM_addr  (DM_addr),
        .DM_in    (DM_in),
        .DM_out   (DM_out)
    );

    logic [31:0] mem [0:1023];
    assign DM_out = DM_read ? mem[DM_addr] : 32'h0;
    always @(posedge clk) if (DM_write) mem[DM_addr] <= DM_in;

    logic [7:0] ref_mem [0:4095];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int passed = 0;
    int since = 0, rd_cnt = 0, wr_cnt = 0, ov_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        since++;
        rd_cnt += int'(DM_read);
        wr_cnt += int'(DM_write);
        ov_cnt += int'(DM_read & DM_write);
        if (bus.rsp_valid) begin
            if (q.size() == 0) begin
                check("rsp_pending", 32'(q.size()), 32'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_latency", 32'(since), 32'(e.lat + 1));
                check("dm_read_cycles", 32'(rd_cnt), 32'(e.rd));
                check("dm_write_cycles", 32'(wr_cnt), 32'(e.wr));
                check("rd_wr_overlap", 32'(ov_cnt), 32'd0);
            end
        end
    end

    // Issue one request; with abort set, reset is pulsed during the write-back cycle.
    task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit abort);
        int n;
        int nb;
        int base;
        exp_t e;
        logic [31:0] v;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("ready_timeout", {31'd0, bus.req_ready}, 32'd1);
            return;
        end
        nb   = 1 << size;
        base = int'(addr[11:0]);
        e.err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        e.rdata = 32'd0;
        if (e.err) begin
            e.lat = 1; e.rd = 0; e.wr = 0;
        end else if (!we) begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v |= 32'(ref_mem[base + i]) << (8 * i);
            if (sgn && nb < 4 && v[8 * nb - 1]) v |= 32'hFFFF_FFFF << (8 * nb);
            e.rdata = v;
            e.lat = 2; e.rd = 1; e.wr = 0;
        end else begin
            if (!abort) for (int i = 0; i < nb; i++) ref_mem[base + i] = wdata[8 * i +: 8];
            e.lat = (nb == 4) ? 2 : 3;
            e.rd  = (nb == 4) ? 0 : 1;
            e.wr  = 1;
        end
        if (!abort) q.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        since = 0; rd_cnt = 0; wr_cnt = 0; ov_cnt = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom();
        bus.req_wdata = $urandom();
        if (abort) begin
            @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            #1;
            check("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
            check("dm_strobes_after_reset", {30'd0, DM_read, DM_write}, 32'd0);
            check("dm_addr_after_reset", {22'd0, DM_addr}, 32'd0);
            check("dm_in_after_reset", DM_in, 32'd0);
            repeat (4) @(negedge clk);
        end else begin
            n = 0;
            while (q.size() != 0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (q.size() != 0) begin
                check("rsp_timeout", 32'(q.size()), 32'd0);
                q.delete();
            end
        end
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, bus.req_ready}, 32'd0);
        check("reset_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        check("reset_rdata", bus.rsp_rdata, 32'd0);
        check("reset_dm", {DM_read, DM_write, DM_addr, DM_in[19:0]}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_release", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);

        do_op(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0);
        do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
        do_op(1'b1, 2'd2, 1'b0, 32'h40, 32'h1122_3344, 1'b0);
        do_op(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, 1'b0);
        do_op(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_0080, 1'b0);
        do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
        do_op(1'b0, 2'd0, 1'b1, 32'h41, 32'h0, 1'b0);
        do_op(1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 1'b0);
        do_op(1'b1, 2'd2, 1'b0, 32'h40, 32'h1122_3344, 1'b0);
        do_op(1'b1, 2'd1, 1'b0, 32'h42, 32'h0000_ABCD, 1'b0);
        do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
        do_op(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 1'b0);
        do_op(1'b0, 2'd1, 1'b1, 32'h41, 32'h0, 1'b0);
        do_op(1'b1, 2'd2, 1'b0, 32'h42, 32'h5555_AAAA, 1'b0);
        do_op(1'b1, 2'd3, 1'b0, 32'h40, 32'h1234_5678, 1'b0);
        do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
        do_op(1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFE_F00D, 1'b0);
        do_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
        do_op(1'b1, 2'd0, 1'b0, 32'h40, 32'h0000_0055, 1'b1);
        do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom(), 1'b0);
        end

        bad = 0;
        for (int w = 0; w < 1024; w++) begin
            if (mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) bad++;
        end
        check("memory_image", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
